// File: rtl/sa_feeder_pkg.sv
// Shared definitions for the systolic-array input feeder: FSM encoding and
// the flush-length helper.
package sa_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_FLUSH  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Zero-padding cycles after the last vector: N-1 skew cycles, N-1 hops
    // across the grid, the PE latency, and the output register.
    function automatic int flush_cycles(input int n, input int pe_lat);
        return 2 * n - 1 + pe_lat;
    endfunction

endpackage

// File: rtl/sa_feeder_skew_line.sv
// Fixed-depth delay line for one operand lane. DEPTH = 0 is a wire.
module skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Lane 0 has no skew; only the feeder's output register delays it.
            logic unused_ok;
            assign unused_ok = ^{clk_i, rst_i, clr_i};
            assign q_o       = d_i;
        end else begin : g_shift
            logic [DEPTH-1:0][WIDTH-1:0] sr_q;

            // Shift one stage per cycle; clear drops any in-flight operands.
            always_ff @(posedge clk_i) begin
                if (rst_i || clr_i) begin
                    sr_q <= '0;
                end else begin
                    sr_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) begin
                        sr_q[i] <= sr_q[i-1];
                    end
                end
            end

            assign q_o = sr_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/sa_feeder.sv
// Input sequencer for an N x N output-stationary systolic array: accepts
// A-column / B-row vectors, applies the diagonal skew, clears the PEs before
// a job and pads zeros until the last product has landed, then pulses done.
module sa_feeder
    import sa_feeder_pkg::*;
#(
    parameter int N      = 8,
    parameter int WIDTH  = 8,
    parameter int KW     = 16,
    parameter int PE_LAT = 1
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               start,
    input  logic [KW-1:0]      k_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH*N-1:0] in_a,
    input  logic [WIDTH*N-1:0] in_b,
    output logic [WIDTH*N-1:0] AA,
    output logic [WIDTH*N-1:0] BB,
    output logic               pe_rst,
    output logic               busy,
    output logic               done
);

    localparam int F  = flush_cycles(N, PE_LAT);
    localparam int FW = $clog2(F + 1);

    state_e             state_q;
    logic [KW-1:0]      cnt_q;
    logic [FW-1:0]      fcnt_q;
    logic               in_ready_q;
    logic               pe_rst_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH*N-1:0] aa_q;
    logic [WIDTH*N-1:0] bb_q;

    logic               xfer;
    logic               clr;
    logic [WIDTH*N-1:0] a_in;
    logic [WIDTH*N-1:0] b_in;
    logic [WIDTH*N-1:0] a_sk;
    logic [WIDTH*N-1:0] b_sk;

    // Non-transfer cycles inject a zero vector so every lane still advances
    // and the diagonal alignment is preserved.
    assign xfer = (state_q == ST_STREAM) && in_ready_q && in_valid;
    assign clr  = (state_q == ST_CLEAR);
    assign a_in = xfer ? in_a : '0;
    assign b_in = xfer ? in_b : '0;

    genvar z;
    generate
        for (z = 0; z < N; z++) begin : g_lane
            skew_line #(.DEPTH(z), .WIDTH(WIDTH)) u_skew_a (
                .clk_i (CLK),
                .rst_i (RST),
                .clr_i (clr),
                .d_i   (a_in[z*WIDTH +: WIDTH]),
                .q_o   (a_sk[z*WIDTH +: WIDTH])
            );
            skew_line #(.DEPTH(z), .WIDTH(WIDTH)) u_skew_b (
                .clk_i (CLK),
                .rst_i (RST),
                .clr_i (clr),
                .d_i   (b_in[z*WIDTH +: WIDTH]),
                .q_o   (b_sk[z*WIDTH +: WIDTH])
            );
        end
    endgenerate

    // Common output register after the skew lines (lane z latency = z + 1).
    always_ff @(posedge CLK) begin
        if (RST) begin
            aa_q <= '0;
            bb_q <= '0;
        end else begin
            aa_q <= a_sk;
            bb_q <= b_sk;
        end
    end

    // Job sequencer; all control outputs are registered alongside the state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            fcnt_q     <= '0;
            in_ready_q <= 1'b0;
            pe_rst_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pe_rst_q   <= 1'b0;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    if (start) begin
                        cnt_q    <= k_len;
                        pe_rst_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state_q  <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    pe_rst_q <= 1'b0;
                    fcnt_q   <= '0;
                    if (cnt_q == '0) begin
                        state_q <= ST_FLUSH;
                    end else begin
                        in_ready_q <= 1'b1;
                        state_q    <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    // cnt_q is at least 1 here, so the decrement cannot wrap.
                    if (xfer) begin
                        cnt_q <= cnt_q - KW'(1);
                        if (cnt_q == KW'(1)) begin
                            in_ready_q <= 1'b0;
                            state_q    <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (fcnt_q == FW'(F - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        fcnt_q <= fcnt_q + FW'(1);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    in_ready_q <= 1'b0;
                    done_q     <= 1'b0;
                    busy_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign AA       = aa_q;
    assign BB       = bb_q;
    assign in_ready = in_ready_q;
    assign pe_rst   = pe_rst_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_sa_feeder.sv
// Directed bench for sa_feeder (N=4, WIDTH=8, PE_LAT=1, F=8) with a
// behavioural output-stationary array model driven from AA/BB/pe_rst.
module tb_sa_feeder;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int KW = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic [KW-1:0] k_len;
    logic          in_valid;
    logic          in_ready;
    logic [N*W-1:0] in_a, in_b, AA, BB;
    logic          pe_rst, busy, done;

    int checks   = 0;
    int failures = 0;

    // Array model state.
    int         acc [N][N];
    logic [W-1:0] ma [N][N];
    logic [W-1:0] mb [N][N];

    // Per-job observations.
    int             ysnap [N][N];
    logic [N*W-1:0] aa_log [40];
    logic [N*W-1:0] bb_log [40];
    int             done_cyc, n_done, n_prst;
    bit             saw_ready;

    always #5 CLK = ~CLK;

    sa_feeder #(.N(N), .WIDTH(W), .KW(KW), .PE_LAT(1)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .k_len    (k_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .AA       (AA),
        .BB       (BB),
        .pe_rst   (pe_rst),
        .busy     (busy),
        .done     (done)
    );

    // Output-stationary grid: A moves right, B moves down, one register per
    // PE before the MAC.
    always @(posedge CLK) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (pe_rst) begin
                    acc[i][j] <= 0;
                    ma[i][j]  <= '0;
                    mb[i][j]  <= '0;
                end else begin
                    ma[i][j]  <= (j == 0) ? AA[i*W +: W] : ma[i][j-1];
                    mb[i][j]  <= (i == 0) ? BB[j*W +: W] : mb[i-1][j];
                    acc[i][j] <= acc[i][j] + int'(ma[i][j]) * int'(mb[i][j]);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [N*W-1:0] ident(input int k);
        logic [N*W-1:0] v;
        v = '0;
        if (k >= 0 && k < N) v[k*W] = 1'b1;
        return v;
    endfunction

    // Runs one job; cycle 0 is the cycle start is presented. Bubbles make
    // in_valid low on even cycles; pulses re-assert start at cycles 3 and 8.
    task automatic run_job(input int kl, input bit bubbles, input bit pulses, input bit skew_vec);
        int idx;
        int cyc;
        idx = 0;
        done_cyc = -1; n_done = 0; n_prst = 0; saw_ready = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) ysnap[i][j] = -1;
        start = 1'b1; k_len = KW'(kl); in_valid = 1'b0;
        step();
        start = 1'b0;
        cyc = 1;
        while (cyc < 40) begin
            aa_log[cyc] = AA;
            bb_log[cyc] = BB;
            if (done) begin
                n_done++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < N; j++) ysnap[i][j] = acc[i][j];
                end
            end
            if (pe_rst) n_prst++;
            if (in_ready) saw_ready = 1;
            start    = pulses && (cyc == 3 || cyc == 8);
            k_len    = pulses ? KW'(9) : KW'(kl);
            in_valid = (idx < kl) && (!bubbles || cyc[0]);
            in_a     = skew_vec ? 32'h0403_0201 : ident(idx);
            in_b     = skew_vec ? 32'h0807_0605 : ident(idx);
            if (in_valid && in_ready) idx++;
            step();
            cyc++;
        end
        start = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    endtask

    task automatic check_identity(input string tag);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk($sformatf("%s_y%0d%0d", tag, i, j), 64'(ysnap[i][j]), (i == j) ? 64'd1 : 64'd0);
    endtask

    initial begin
        logic [N*W-1:0] ea, eb;
        int dcount;

        RST = 1'b1; start = 1'b0; k_len = '0; in_valid = 1'b0; in_a = '0; in_b = '0;
        step(); step();
        chk("rst_aa",     64'(AA), 64'd0);
        chk("rst_bb",     64'(BB), 64'd0);
        chk("rst_pe_rst", 64'(pe_rst), 64'd1);
        chk("rst_ready",  64'(in_ready), 64'd0);
        chk("rst_busy",   64'(busy), 64'd0);
        chk("rst_done",   64'(done), 64'd0);
        RST = 1'b0;
        step(); step();
        chk("idle_pe_rst", 64'(pe_rst), 64'd0);

        // Skew: single vector, lane z visible only at cycle 3+z.
        run_job(1, 1'b0, 1'b0, 1'b1);
        chk("skew_done_cyc", 64'(done_cyc), 64'd11);
        chk("skew_n_done",   64'(n_done), 64'd1);
        for (int c = 1; c < 20; c++) begin
            ea = '0; eb = '0;
            for (int z = 0; z < N; z++) begin
                if (c == 3 + z) begin
                    ea[z*W +: W] = W'(z + 1);
                    eb[z*W +: W] = W'(z + 5);
                end
            end
            chk($sformatf("skew_aa_c%0d", c), 64'(aa_log[c]), 64'(ea));
            chk($sformatf("skew_bb_c%0d", c), 64'(bb_log[c]), 64'(eb));
        end

        // Identity x identity, continuous valid.
        run_job(4, 1'b0, 1'b0, 1'b0);
        chk("full_done_cyc", 64'(done_cyc), 64'd14);
        chk("full_n_done",   64'(n_done), 64'd1);
        chk("full_n_prst",   64'(n_prst), 64'd1);
        check_identity("full");

        // Same job with a bubble every other cycle.
        run_job(4, 1'b1, 1'b0, 1'b0);
        chk("bub_done_cyc", 64'(done_cyc), 64'd18);
        chk("bub_n_done",   64'(n_done), 64'd1);
        check_identity("bub");

        // Empty job.
        run_job(0, 1'b0, 1'b0, 1'b0);
        chk("k0_done_cyc", 64'(done_cyc), 64'd10);
        chk("k0_n_done",   64'(n_done), 64'd1);
        chk("k0_n_prst",   64'(n_prst), 64'd1);
        chk("k0_ready",    64'(saw_ready), 64'd0);

        // Start pulses while busy must not disturb the running job.
        run_job(4, 1'b0, 1'b1, 1'b0);
        chk("pulse_done_cyc", 64'(done_cyc), 64'd14);
        chk("pulse_n_done",   64'(n_done), 64'd1);
        check_identity("pulse");

        // Reset in the middle of STREAM.
        start = 1'b1; k_len = KW'(4);
        step();
        start = 1'b0; in_valid = 1'b1; in_a = ident(0); in_b = ident(0);
        step(); step();
        chk("mid_busy_pre", 64'(busy), 64'd1);
        RST = 1'b1;
        step();
        chk("mid_rst_aa",     64'(AA), 64'd0);
        chk("mid_rst_bb",     64'(BB), 64'd0);
        chk("mid_rst_pe_rst", 64'(pe_rst), 64'd1);
        chk("mid_rst_busy",   64'(busy), 64'd0);
        chk("mid_rst_ready",  64'(in_ready), 64'd0);
        step();
        chk("mid_rst2_busy",  64'(busy), 64'd0);
        RST = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        dcount = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (done) dcount++;
        end
        chk("mid_rst_no_done", 64'(dcount), 64'd0);
        chk("mid_rst_idle_busy", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sa_feeder.md
Name: sa_feeder

Overview:
- Input-side sequencer for the 2D output-stationary systolic array (PE_OS_16 grid).
- Accepts one A column-vector and one B row-vector per handshake, applies the triangular diagonal skew, and drives the array's AA/BB buses.
- Clears the PE accumulators before each job, pads zeros until the last product has settled, then pulses done so a downstream reader can capture Y.

Parameters:
- N, 8: array dimension. Square only; HPE = VPE = N.
- WIDTH, 8: operand width per lane.
- KW, 16: width of the k_len job-length field.
- PE_LAT, 1: register stages inside one PE between operand arrival and MAC update.

Ports:
- CLK  in  1  clock (only clock).
- RST  in  1  synchronous, active-high reset.
- start  in  1  begin job; sampled in IDLE only.
- k_len  in  KW  number of input vectors in the job; captured on start.
- in_valid  in  1  in_a/in_b valid.
- in_ready  out  1  feeder accepts a vector this cycle.
- in_a  in  WIDTH*N  A column vector, lane z = bits [(z+1)*WIDTH-1 : z*WIDTH], row z.
- in_b  in  WIDTH*N  B row vector, lane z feeds column z.
- AA  out  WIDTH*N  to array AA.
- BB  out  WIDTH*N  to array BB.
- pe_rst  out  1  to array RST; clears accumulators.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse: Y is final.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high. Every output is registered.
- Reset values: AA = 0, BB = 0, pe_rst = 1, in_ready = 0, busy = 0, done = 0, state = IDLE. All skew registers cleared to 0.
- IDLE:
  - pe_rst = 0, in_ready = 0, AA/BB = 0.
  - start = 1 → latch k_len into cnt, go to CLEAR.
- CLEAR:
  - Exactly one cycle. pe_rst = 1, skew lines flushed to 0.
  - If cnt == 0 go to FLUSH, else go to STREAM.
- STREAM:
  - in_ready = 1.
  - A transfer occurs on in_valid & in_ready; cnt decrements.
  - On a cycle with no transfer, a zero vector enters all lanes (bubble). Zero × anything adds 0, and alignment holds because every lane advances every cycle.
  - The transfer that brings cnt to 0 moves to FLUSH; in_ready drops the next cycle.
- FLUSH:
  - Zeros are injected for F = 2*N - 1 + PE_LAT cycles.
  - F covers N-1 skew cycles, N-1 propagation hops, the PE latency and the output register.
  - Afterwards go to DONE.
- DONE: one cycle, done = 1, then back to IDLE.
- busy = 1 in every state except IDLE.
- Skew:
  - Lane z of both A and B passes through a z-deep delay line, followed by the common output register.
  - A value accepted on lane z at cycle t appears on AA/BB lane z at cycle t + z + 1.
  - Lane 0 therefore has a 1-cycle latency.
- start while busy: ignored, with no effect on the current job.
- k_len = 0: CLEAR → FLUSH → DONE. Y stays 0. Total 2 + F cycles from start to done.
- RST mid-job: next cycle is exactly the reset state. The partial job is abandoned, no done pulse, and the skew contents are discarded.
- Arithmetic: no arithmetic on data. cnt is KW bits and never wraps, because decrement happens only while cnt > 0.

Decomposition:
- Shared header sa_defs.vh holds:
  - state encodings IDLE = 0, CLEAR = 1, STREAM = 2, FLUSH = 3, DONE = 4 (3-bit);
  - the flush-count function F(N, PE_LAT);
  - the lane-slice macro.
- Sub-module skew_line (parameters DEPTH, WIDTH):
  - DEPTH-stage shift register with synchronous clear;
  - DEPTH = 0 is a pass-through;
  - instantiated 2N times via generate.

Test Plan (N = 4, WIDTH = 8, PE_LAT = 1, F = 8):
- Reset: assert RST for 2 cycles mid-STREAM → AA = BB = 0, pe_rst = 1, busy = 0. No done follows within 20 cycles.
- Skew check: k_len = 1, in_a = 0x04030201, in_b = 0x08070605, in_valid held high.
  - AA lanes show 01, 02, 03, 04 at cycles t+1, t+2, t+3, t+4 respectively; BB lanes likewise show 05..08.
  - All other cycles are zero.
- Full job with array model: A = B = 4x4 identity, k_len = 4, continuous valid.
  - done fires 1 + 4 + 8 + 1 cycles after start.
  - The Y model equals identity (diagonal entries 1, all others 0).
- Bubbles: same job as the full-job case with in_valid low on alternate cycles → identical Y result; done is 4 cycles later than with continuous valid.
- k_len = 0: done fires exactly 10 cycles after start; pe_rst is high for exactly 1 cycle; in_ready is never 1.
- start pulses during STREAM and FLUSH are ignored: exactly one done, and the job length is unchanged.
